// File: rtl/nor_chain_scheduler.sv
// Round-robin scheduler that shares one 2-input NOR stage between two requesters,
// evaluating the cascaded chain s0 = ~(x0|x1), sk = ~(s(k-1)|x(k+1)) one step per clock.
module nor_chain_scheduler #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic [N_IN-1:0] opnd0,
    input  logic            req1,
    input  logic [N_IN-1:0] opnd1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            busy,
    output logic            done,
    output logic            owner,
    output logic [N_IN-2:0] stage_out,
    output logic            result
);

    localparam int STEP_W = $clog2(N_IN);

    typedef enum logic {IDLE, EVAL} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last;
    logic [N_IN-1:0]   r_opnd;
    logic [STEP_W-1:0] r_step;
    logic              r_acc;

    logic w_grant;
    logic w_pick1;
    logic w_last_step;
    logic w_in;
    logic w_x_next;
    logic w_acc;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req0 || req1) w_next_state = EVAL;
            EVAL:    if (w_last_step)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before any conditional so no latch is inferred.
    always_comb begin
        w_grant     = (r_state == IDLE) && (req0 || req1);
        // On a tie the requester that was not served last wins.
        w_pick1     = req1 && (!req0 || !r_last);
        w_last_step = (r_state == EVAL) && (r_step == STEP_W'(N_IN - 2));
        w_in        = (r_step == '0) ? r_opnd[0] : r_acc;
        w_x_next    = 1'b0;
        for (int k = 1; k < N_IN; k++) begin
            if (r_step == STEP_W'(k - 1)) w_x_next = r_opnd[k];
        end
        w_acc = ~(w_in | w_x_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            owner     <= 1'b0;
            stage_out <= '0;
            result    <= 1'b0;
            r_last    <= 1'b1;
            r_opnd    <= '0;
            r_step    <= '0;
            r_acc     <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            if (w_grant) begin
                gnt0   <= !w_pick1;
                gnt1   <= w_pick1;
                r_opnd <= w_pick1 ? opnd1 : opnd0;
                owner  <= w_pick1;
                r_last <= w_pick1;
                r_step <= '0;
                busy   <= 1'b1;
            end else if (r_state == EVAL) begin
                r_acc  <= w_acc;
                r_step <= r_step + STEP_W'(1);
                for (int k = 0; k < N_IN - 1; k++) begin
                    if (r_step == STEP_W'(k)) stage_out[k] <= w_acc;
                end
                if (w_last_step) begin
                    result <= w_acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule
